// File: rtl/mac_arbiter.sv
// Four-requester round-robin front end for a shared, in-order MAC pipeline.
// A tag FIFO records which requester owns each issued operation. Returning
// results are steered back to that requester in issue order.
module mac_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               req_valid,
  output logic [3:0]               req_ready,
  input  logic [4*DW-1:0]          req_a,
  input  logic [4*DW-1:0]          req_b,
  input  logic [4*DW-1:0]          req_c,
  input  logic [4*DW-1:0]          req_d,
  output logic [DW-1:0]            mac_a,
  output logic [DW-1:0]            mac_b,
  output logic [DW-1:0]            mac_c,
  output logic [DW-1:0]            mac_d,
  output logic                     mac_valid,
  input  logic                     mac_ready,
  input  logic [2*DW-1:0]          mac_res,
  input  logic                     mac_res_valid,
  output logic                     mac_res_ready,
  output logic [2*DW-1:0]          rsp_data,
  output logic [3:0]               rsp_valid,
  input  logic [3:0]               rsp_ready,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   INF_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]    ptr;
  logic [1:0]    grant;
  logic [1:0]    tags [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [1:0]    head;
  logic          busy, full, issue, pop;

  assign busy  = (inflight != '0);
  assign full  = (inflight == FULL_CNT);
  assign head  = tags[rptr];

  // Round-robin search starting at ptr; the lowest offset with a request wins.
  always_comb begin
    logic [1:0] idx;
    grant = ptr;
    idx   = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_valid[idx]) grant = idx;
    end
  end

  // Issue side: combinational grant straight to the MAC, blocked when full
  // (a pop in the same cycle does not free a slot until the next cycle).
  always_comb begin
    mac_valid = !reset && (|req_valid) && !full;
    issue     = mac_valid && mac_ready;
    req_ready = '0;
    if (issue) req_ready[grant] = 1'b1;
    mac_a = mac_valid ? req_a[grant*DW +: DW] : '0;
    mac_b = mac_valid ? req_b[grant*DW +: DW] : '0;
    mac_c = mac_valid ? req_c[grant*DW +: DW] : '0;
    mac_d = mac_valid ? req_d[grant*DW +: DW] : '0;
  end

  // Return side: route the result to the head tag's owner; with nothing in
  // flight, accept unconditionally so stray results drain instead of hanging.
  always_comb begin
    rsp_valid     = '0;
    mac_res_ready = 1'b0;
    if (!reset) begin
      mac_res_ready = busy ? rsp_ready[head] : 1'b1;
      for (int i = 0; i < 4; i++)
        rsp_valid[i] = mac_res_valid && busy && (head == 2'(i));
    end
    rsp_data = (|rsp_valid) ? mac_res : '0;
    pop      = mac_res_valid && mac_res_ready && busy;
  end

  // Tag storage: written on issue, contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (issue) tags[wptr] <= grant;
  end

  // Pointer, occupancy and sticky orphan-error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      inflight   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue) begin
        wptr <= wptr + PTR_ONE;
        ptr  <= grant + 2'd1;
      end
      if (pop) rptr <= rptr + PTR_ONE;
      case ({issue, pop})
        2'b10:   inflight <= inflight + INF_ONE;
        2'b01:   inflight <= inflight - INF_ONE;
        default: inflight <= inflight;
      endcase
      if (mac_res_valid && mac_res_ready && !busy) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: a cycle table for rotation, result return,
// fairness, withdrawal, full and stall cases, plus short hand sequences.
// Requester i operands: a=4i+1, b=4i+2, c=4i+3, d=4i+4.
// Results (a+b)*(c+d): req0 21, req1 165, req2 437, req3 837.
module tb_mac_arbiter;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req_valid, req_ready;
  logic [4*DW-1:0] req_a, req_b, req_c, req_d;
  logic [DW-1:0]  mac_a, mac_b, mac_c, mac_d;
  logic           mac_valid, mac_ready;
  logic [2*DW-1:0] mac_res, rsp_data;
  logic           mac_res_valid, mac_res_ready;
  logic [3:0]     rsp_valid, rsp_ready;
  logic [2:0]     inflight;
  logic           err_orphan;

  int checks = 0;
  int errors = 0;

  mac_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
    .mac_valid(mac_valid), .mac_ready(mac_ready),
    .mac_res(mac_res), .mac_res_valid(mac_res_valid), .mac_res_ready(mac_res_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic        mr;
    logic        resv;
    logic [15:0] res;
    logic [3:0]  rr;
    logic [3:0]  e_rdy;
    logic        e_mv;
    logic [7:0]  e_a;
    logic [3:0]  e_rspv;
    logic [15:0] e_dat;
    logic        e_mrr;
    logic [2:0]  e_inf;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mk(logic [3:0] rv, logic mr, logic resv, logic [15:0] res,
                              logic [3:0] rr, logic [3:0] e_rdy, logic e_mv, logic [7:0] e_a,
                              logic [3:0] e_rspv, logic [15:0] e_dat, logic e_mrr,
                              logic [2:0] e_inf);
    vec_t v;
    v.rv = rv; v.mr = mr; v.resv = resv; v.res = res; v.rr = rr;
    v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_a = e_a; v.e_rspv = e_rspv;
    v.e_dat = e_dat; v.e_mrr = e_mrr; v.e_inf = e_inf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change right after the falling edge; outputs are sampled 2 time
  // units later, well before the next rising edge.
  task automatic drive(input logic rst, input logic [3:0] rv, input logic mr,
                       input logic resv, input logic [15:0] res, input logic [3:0] rr);
    @(negedge clk);
    reset = rst; req_valid = rv; mac_ready = mr;
    mac_res_valid = resv; mac_res = res; rsp_ready = rr;
    #2;
  endtask

  initial begin
    int n_iss;
    for (int i = 0; i < 4; i++) begin
      req_a[i*DW +: DW] = 8'(4*i + 1);
      req_b[i*DW +: DW] = 8'(4*i + 2);
      req_c[i*DW +: DW] = 8'(4*i + 3);
      req_d[i*DW +: DW] = 8'(4*i + 4);
    end
    reset = 1'b1; req_valid = '0; mac_ready = 1'b0;
    mac_res_valid = 1'b0; mac_res = '0; rsp_ready = '0;

    //            rv    mr resv res   rr    rdy  mv a   rspv dat  mrr inf
    vecs[0]  = mk(4'hF, 1, 0, 0,   4'hF, 4'h1, 1, 1,  4'h0, 0,   1, 0);
    vecs[1]  = mk(4'hF, 1, 0, 0,   4'hF, 4'h2, 1, 5,  4'h0, 0,   1, 1);
    vecs[2]  = mk(4'hF, 1, 0, 0,   4'hF, 4'h4, 1, 9,  4'h0, 0,   1, 2);
    vecs[3]  = mk(4'hF, 1, 1, 21,  4'hF, 4'h8, 1, 13, 4'h1, 21,  1, 3);
    vecs[4]  = mk(4'hF, 1, 1, 165, 4'hF, 4'h1, 1, 1,  4'h2, 165, 1, 3);
    vecs[5]  = mk(4'hF, 1, 1, 437, 4'hF, 4'h2, 1, 5,  4'h4, 437, 1, 3);
    vecs[6]  = mk(4'h0, 1, 1, 837, 4'hF, 4'h0, 0, 0,  4'h8, 837, 1, 3);
    vecs[7]  = mk(4'h0, 1, 1, 21,  4'hF, 4'h0, 0, 0,  4'h1, 21,  1, 2);
    vecs[8]  = mk(4'h0, 1, 1, 165, 4'hF, 4'h0, 0, 0,  4'h2, 165, 1, 1);
    vecs[9]  = mk(4'h0, 1, 0, 0,   4'hF, 4'h0, 0, 0,  4'h0, 0,   1, 0);
    // only req1/req3 valid with ptr=2: grants 3,1,3
    vecs[10] = mk(4'hA, 1, 0, 0,   4'hF, 4'h8, 1, 13, 4'h0, 0,   1, 0);
    vecs[11] = mk(4'hA, 1, 0, 0,   4'hF, 4'h2, 1, 5,  4'h0, 0,   1, 1);
    vecs[12] = mk(4'hA, 1, 0, 0,   4'hF, 4'h8, 1, 13, 4'h0, 0,   1, 2);
    // stalled MAC, req1 withdraws then returns: ptr must not move
    vecs[13] = mk(4'hA, 0, 0, 0,   4'hF, 4'h0, 1, 5,  4'h0, 0,   1, 3);
    vecs[14] = mk(4'h8, 0, 0, 0,   4'hF, 4'h0, 1, 13, 4'h0, 0,   1, 3);
    vecs[15] = mk(4'hA, 1, 0, 0,   4'hF, 4'h2, 1, 5,  4'h0, 0,   1, 3);
    // full: a pop this cycle gives no issue credit
    vecs[16] = mk(4'hF, 1, 1, 837, 4'hF, 4'h0, 0, 0,  4'h8, 837, 1, 4);
    vecs[17] = mk(4'hF, 1, 0, 0,   4'hF, 4'h4, 1, 9,  4'h0, 0,   1, 3);
    vecs[18] = mk(4'h0, 1, 1, 165, 4'hF, 4'h0, 0, 0,  4'h2, 165, 1, 4);
    vecs[19] = mk(4'h0, 1, 1, 837, 4'hF, 4'h0, 0, 0,  4'h8, 837, 1, 3);
    vecs[20] = mk(4'h0, 1, 1, 165, 4'hF, 4'h0, 0, 0,  4'h2, 165, 1, 2);
    // head tag 2 with rsp_ready[2]=0 stalls, then releases
    vecs[21] = mk(4'h0, 1, 1, 437, 4'hB, 4'h0, 0, 0,  4'h4, 437, 0, 1);
    vecs[22] = mk(4'h0, 1, 1, 437, 4'hB, 4'h0, 0, 0,  4'h4, 437, 0, 1);
    vecs[23] = mk(4'h0, 1, 1, 437, 4'hF, 4'h0, 0, 0,  4'h4, 437, 1, 1);
    vecs[24] = mk(4'h0, 1, 0, 0,   4'hF, 4'h0, 0, 0,  4'h0, 0,   1, 0);

    // Reset: outputs forced low even with every input active.
    drive(1'b1, 4'hF, 1'b1, 1'b1, 16'd99, 4'hF);
    drive(1'b1, 4'hF, 1'b1, 1'b1, 16'd99, 4'hF);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mac_valid", 32'(mac_valid), 0);
    chk("rst_mac_res_ready", 32'(mac_res_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mac_a", 32'(mac_a), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err_orphan", 32'(err_orphan), 0);

    for (int i = 0; i < 25; i++) begin
      vec_t v;
      logic [7:0] eo;
      v = vecs[i];
      drive(1'b0, v.rv, v.mr, v.resv, v.res, v.rr);
      eo = (v.e_a == 8'd0) ? 8'd0 : v.e_a + 8'd1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(v.e_rdy));
      chk($sformatf("v%0d_mac_valid", i), 32'(mac_valid), 32'(v.e_mv));
      chk($sformatf("v%0d_mac_a", i), 32'(mac_a), 32'(v.e_a));
      chk($sformatf("v%0d_mac_b", i), 32'(mac_b), 32'(eo));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(v.e_rspv));
      chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(v.e_dat));
      chk($sformatf("v%0d_mac_res_ready", i), 32'(mac_res_ready), 32'(v.e_mrr));
      chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(v.e_inf));
      chk($sformatf("v%0d_err_orphan", i), 32'(err_orphan), 0);
    end

    // Six cycles of pending requests with no results: exactly four issues.
    n_iss = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'hF, 1'b1, 1'b0, 16'd0, 4'hF);
      if (mac_valid && mac_ready) n_iss++;
      if (i >= 4) chk("full_mac_valid", 32'(mac_valid), 0);
    end
    chk("full_issue_count", 32'(n_iss), 4);
    chk("full_inflight", 32'(inflight), 4);
    // One result (head = req3, first grant from ptr=3); no same-cycle credit.
    drive(1'b0, 4'hF, 1'b1, 1'b1, 16'd837, 4'hF);
    chk("pop_no_credit", 32'(mac_valid), 0);
    chk("pop_rsp_valid", 32'(rsp_valid), 32'(4'h8));
    drive(1'b0, 4'hF, 1'b1, 1'b0, 16'd0, 4'hF);
    chk("freed_mac_valid", 32'(mac_valid), 1);
    chk("freed_req_ready", 32'(req_ready), 32'(4'h8));
    chk("freed_inflight", 32'(inflight), 3);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b1, 1'b1, 16'd1, 4'hF);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 16'd0, 4'hF);
    chk("drained_inflight", 32'(inflight), 0);

    // Orphan result with nothing in flight.
    drive(1'b0, 4'h0, 1'b1, 1'b1, 16'd77, 4'hF);
    chk("orphan_rsp_valid", 32'(rsp_valid), 0);
    chk("orphan_rsp_data", 32'(rsp_data), 0);
    chk("orphan_mac_res_ready", 32'(mac_res_ready), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0, 16'd0, 4'hF);
      chk("orphan_sticky", 32'(err_orphan), 1);
    end

    // Reset mid-operation with two ops in flight.
    drive(1'b0, 4'hF, 1'b1, 1'b0, 16'd0, 4'hF);
    drive(1'b0, 4'hF, 1'b1, 1'b0, 16'd0, 4'hF);
    drive(1'b1, 4'hF, 1'b1, 1'b1, 16'd5, 4'hF);
    chk("mid_inflight_before", 32'(inflight), 2);
    chk("mid_rst_mac_valid", 32'(mac_valid), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_mac_res_ready", 32'(mac_res_ready), 0);
    chk("mid_rst_mac_d", 32'(mac_d), 0);
    drive(1'b0, 4'hF, 1'b0, 1'b0, 16'd0, 4'hF);
    chk("after_rst_inflight", 32'(inflight), 0);
    chk("after_rst_err", 32'(err_orphan), 0);
    chk("after_rst_grant0", 32'(mac_a), 1);
    chk("after_rst_mac_valid", 32'(mac_valid), 1);
    // A late result for a discarded tag is an orphan.
    drive(1'b0, 4'h0, 1'b0, 1'b1, 16'd21, 4'hF);
    chk("late_rsp_valid", 32'(rsp_valid), 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 16'd0, 4'hF);
    chk("late_orphan_err", 32'(err_orphan), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
